// File: rtl/ff_comb_mac.sv
// Two-stage pipelined signed multiply-accumulate with a sticky signed-overflow flag.
// Stage 1 registers the operands; stage 2 adds their product into the accumulator.
module ff_comb_mac #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    output logic                    valid_out,
    output logic signed [OUT_W-1:0] f,
    output logic                    overflow
);

    logic signed [IN_W-1:0]    a_q, b_q;
    logic                      v_q;
    logic signed [OUT_W-1:0]   f_q, f_d;
    logic                      ovf_q, ovf_d;
    logic                      vout_q, vout_d;

    logic signed [2*IN_W-1:0]  prod_full;
    logic signed [OUT_W-1:0]   prod_ext;
    logic signed [OUT_W-1:0]   sum;
    logic                      add_ovf;

    // Operands are widened before multiplying so the full signed product is kept.
    assign prod_full = $signed({{IN_W{a_q[IN_W-1]}}, a_q}) * $signed({{IN_W{b_q[IN_W-1]}}, b_q});

    generate
        if (OUT_W > 2*IN_W) begin : g_ext
            assign prod_ext = {{(OUT_W-2*IN_W){prod_full[2*IN_W-1]}}, prod_full};
        end else begin : g_noext
            assign prod_ext = prod_full[OUT_W-1:0];
        end
    endgenerate

    assign sum     = f_q + prod_ext;
    assign add_ovf = (prod_ext[OUT_W-1] == f_q[OUT_W-1]) && (sum[OUT_W-1] != f_q[OUT_W-1]);

    always_comb begin
        f_d    = f_q;
        ovf_d  = ovf_q;
        vout_d = 1'b0;
        if (v_q) begin
            f_d    = sum;
            ovf_d  = ovf_q | add_ovf;
            vout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            v_q    <= 1'b0;
            f_q    <= '0;
            ovf_q  <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            v_q    <= valid_in;
            f_q    <= f_d;
            ovf_q  <= ovf_d;
            vout_q <= vout_d;
        end
    end

    assign f         = f_q;
    assign overflow  = ovf_q;
    assign valid_out = vout_q;

endmodule

// File: tb/tb_ff_comb_mac.sv
// Directed and randomized checks of ff_comb_mac against an arithmetic accumulator model
// that tracks in-flight pairs by the edge on which they were sampled.
module tb_ff_comb_mac;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam longint MAXV = (64'sd1 <<< (OUT_W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OUT_W-1));

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic signed [IN_W-1:0]  a = '0;
    logic signed [IN_W-1:0]  b = '0;
    logic                    valid_in = 1'b0;
    logic                    valid_out;
    logic signed [OUT_W-1:0] f;
    logic                    overflow;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    typedef struct {
        int     edge_no;
        longint prod;
    } flight_t;

    flight_t flight_q[$];
    longint  mf = 0;
    logic    mo = 1'b0;
    logic    mv = 1'b0;

    ff_comb_mac #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in),
        .valid_out(valid_out), .f(f), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic longint wrap(input longint x);
        longint m;
        m = x & ((64'sd1 <<< OUT_W) - 1);
        if (m > MAXV) m = m - (64'sd1 <<< OUT_W);
        return m;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic chk_model();
        chk("f_model", longint'(f), mf);
        chk("valid_out_model", longint'(valid_out), longint'(mv));
        chk("overflow_model", longint'(overflow), longint'(mo));
    endtask

    task automatic model_clear();
        flight_q.delete();
        mf = 0;
        mo = 1'b0;
        mv = 1'b0;
    endtask

    // Advance one rising edge, update the model, then check #1 after the edge.
    task automatic tick();
        flight_t e;
        longint  exact;
        @(posedge clk);
        edge_no++;
        if (reset) begin
            model_clear();
        end else begin
            mv = 1'b0;
            if (flight_q.size() > 0 && flight_q[0].edge_no == edge_no - 1) begin
                e     = flight_q.pop_front();
                exact = mf + e.prod;
                if (exact > MAXV || exact < MINV) mo = 1'b1;
                mf = wrap(exact);
                mv = 1'b1;
            end
            if (valid_in) flight_q.push_back('{edge_no, longint'(a) * longint'(b)});
        end
        #1;
        chk_model();
    endtask

    task automatic drive(input int av, input int bv, input logic vv);
        a        = IN_W'(av);
        b        = IN_W'(bv);
        valid_in = vv;
    endtask

    // Asynchronous reset pulse landing between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("rst_async_f", longint'(f), 0);
        chk("rst_async_vout", longint'(valid_out), 0);
        chk("rst_async_ovf", longint'(overflow), 0);
        tick();
        #2 reset = 1'b0;
    endtask

    initial begin
        // Reset held across edges.
        #1;
        chk("rst_f", longint'(f), 0);
        tick();
        drive(7, 9, 1'b1);
        tick();
        drive(0, 0, 1'b0);
        #2 reset = 1'b0;

        // Gapped stream from the test plan.
        tick();                                   // edge 1
        chk("gap_e1_f", longint'(f), 0);
        drive(1, 1, 1'b0);
        tick();                                   // edge 2
        drive(2, 2, 1'b1);
        tick();                                   // edge 3
        chk("gap_e3_vout", longint'(valid_out), 0);
        drive(3, 3, 1'b1);
        tick();                                   // edge 4
        chk("gap_e4_f", longint'(f), 4);
        chk("gap_e4_vout", longint'(valid_out), 1);
        drive(4, 4, 1'b0);
        tick();                                   // edge 5
        chk("gap_e5_f", longint'(f), 13);
        drive(5, 5, 1'b0);
        tick();                                   // edge 6
        chk("gap_e6_vout", longint'(valid_out), 0);
        drive(6, 6, 1'b1);
        tick();                                   // edge 7
        chk("gap_e7_f", longint'(f), 13);
        drive(0, 0, 1'b0);
        tick();                                   // edge 8
        chk("gap_e8_f", longint'(f), 49);
        chk("gap_e8_vout", longint'(valid_out), 1);

        // Negative overflow wrap, then sticky flag under small adds.
        pulse_reset();
        drive(-100, 120, 1'b1);
        tick();
        tick();
        chk("neg_f1", longint'(f), -12000);
        tick();
        chk("neg_f2", longint'(f), -24000);
        chk("neg_ovf2", longint'(overflow), 0);
        tick();
        chk("neg_f3", longint'(f), 29536);
        chk("neg_ovf3", longint'(overflow), 1);
        tick();
        chk("neg_f4", longint'(f), 17536);
        chk("neg_ovf4", longint'(overflow), 1);
        drive(1, 1, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("sticky_ovf", longint'(overflow), 1);

        // Idle hold with a/b toggling.
        drive(0, 0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(int'($urandom), int'($urandom), 1'b0);
            tick();
        end
        chk("idle_vout", longint'(valid_out), 0);

        // Positive overflow.
        pulse_reset();
        drive(-128, -128, 1'b1);
        tick();
        tick();
        chk("pos_f1", longint'(f), 16384);
        chk("pos_ovf1", longint'(overflow), 0);
        tick();
        chk("pos_f2", longint'(f), -32768);
        chk("pos_ovf2", longint'(overflow), 1);

        // Mid-stream asynchronous reset with pairs in flight.
        drive(50, 60, 1'b1);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        model_clear();
        chk("mid_f", longint'(f), 0);
        chk("mid_vout", longint'(valid_out), 0);
        chk("mid_ovf", longint'(overflow), 0);
        tick();
        drive(3, -4, 1'b1);
        #2 reset = 1'b0;
        tick();
        chk("mid_first_vout", longint'(valid_out), 0);
        drive(0, 0, 1'b0);
        tick();
        chk("mid_first_f", longint'(f), -12);
        chk("mid_first_vout2", longint'(valid_out), 1);

        // Randomized stream with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom), int'($urandom), 1'(($urandom_range(0, 3) != 0)));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
